// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Shared UART types, ctrl field positions and frame-format helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    localparam int CTRL_LEN_LSB = 0;
    localparam int CTRL_PAR_EN  = 2;
    localparam int CTRL_ODD     = 3;
    localparam int CTRL_STOP2   = 4;
    localparam int CTRL_USED_W  = 5;

    localparam int TICKS_PER_BIT_DEFAULT = 16;

    function automatic logic [3:0] data_bits(input logic [1:0] len_sel);
        return 4'd5 + {2'b00, len_sel};
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module : uart_tx_serializer
// UART transmit shifter with a one-byte holding register and sticky overrun.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEFAULT,
    parameter int DATA_W        = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              baud_tick,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [6:0]        ctrl,
    input  logic              ovr_clr,
    output logic              TXD,
    output logic              TXdone,
    output logic              tx_busy,
    output logic              tx_buffer_overrun
);

    localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);

    tx_state_t               r_state, w_state_nxt;
    logic [TICK_W-1:0]       r_tick, w_tick_nxt;
    logic [2:0]              r_bitcnt, w_bitcnt_nxt;
    logic [DATA_W-1:0]       r_shift, w_shift_nxt;
    logic [CTRL_USED_W-1:0]  r_ctrl, w_ctrl_nxt;
    logic                    r_par, w_par_nxt;
    logic [DATA_W-1:0]       r_hold_data, w_hold_data_nxt;
    logic [CTRL_USED_W-1:0]  r_hold_ctrl, w_hold_ctrl_nxt;
    logic                    r_hold_valid, w_hold_valid_nxt;
    logic                    r_txd, w_txd_nxt;
    logic                    r_ovr, w_ovr_nxt;
    logic                    w_bit_end, w_done, w_unload, w_last_data;
    logic [CTRL_USED_W-1:0]  w_ctrl_fmt;

    // ctrl[6:5] carry no meaning here and are discarded by the cast
    assign w_ctrl_fmt = CTRL_USED_W'(ctrl);

    function automatic logic f_parity(input logic [DATA_W-1:0] d,
                                      input logic [CTRL_USED_W-1:0] c);
        logic p;
        p = c[CTRL_ODD];
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(data_bits(c[CTRL_LEN_LSB +: 2]))) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction

    assign w_bit_end   = baud_tick && (r_tick == c_TICK_LAST);
    assign w_last_data = ({1'b0, r_bitcnt} == (data_bits(r_ctrl[CTRL_LEN_LSB +: 2]) - 4'd1));

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick;
        w_bitcnt_nxt     = r_bitcnt;
        w_shift_nxt      = r_shift;
        w_ctrl_nxt       = r_ctrl;
        w_par_nxt        = r_par;
        w_hold_data_nxt  = r_hold_data;
        w_hold_ctrl_nxt  = r_hold_ctrl;
        w_hold_valid_nxt = r_hold_valid;
        w_ovr_nxt        = r_ovr;
        w_txd_nxt        = 1'b1;
        w_done           = 1'b0;
        w_unload         = 1'b0;

        if ((r_state != S_IDLE) && baud_tick) begin
            w_tick_nxt = w_bit_end ? '0 : r_tick + 1'b1;
        end

        unique case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_shift_nxt = tx_data;
                    w_ctrl_nxt  = w_ctrl_fmt;
                    w_par_nxt   = f_parity(tx_data, w_ctrl_fmt);
                    w_tick_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (w_last_data) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = r_ctrl[CTRL_PAR_EN] ? S_PARITY : S_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_ctrl[CTRL_STOP2] && (r_bitcnt == 3'd0)) begin
                        w_bitcnt_nxt = 3'd1;
                    end else begin
                        w_done       = 1'b1;
                        w_bitcnt_nxt = '0;
                        if (r_hold_valid) begin
                            w_unload         = 1'b1;
                            w_shift_nxt      = r_hold_data;
                            w_ctrl_nxt       = r_hold_ctrl;
                            w_par_nxt        = f_parity(r_hold_data, r_hold_ctrl);
                            w_hold_valid_nxt = 1'b0;
                            w_state_nxt      = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (ovr_clr) begin
            w_ovr_nxt = 1'b0;
        end

        // The slot being unloaded this cycle can take a new byte at once
        if (tx_start && (r_state != S_IDLE)) begin
            if (!r_hold_valid || w_unload) begin
                w_hold_data_nxt  = tx_data;
                w_hold_ctrl_nxt  = w_ctrl_fmt;
                w_hold_valid_nxt = 1'b1;
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end

        unique case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
            S_PARITY: w_txd_nxt = w_par_nxt;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_ctrl       <= '0;
            r_par        <= 1'b0;
            r_hold_data  <= '0;
            r_hold_ctrl  <= '0;
            r_hold_valid <= 1'b0;
            r_txd        <= 1'b1;
            r_ovr        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_shift      <= w_shift_nxt;
            r_ctrl       <= w_ctrl_nxt;
            r_par        <= w_par_nxt;
            r_hold_data  <= w_hold_data_nxt;
            r_hold_ctrl  <= w_hold_ctrl_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_txd        <= w_txd_nxt;
            r_ovr        <= w_ovr_nxt;
        end
    end

    assign TXD               = r_txd;
    assign TXdone            = w_done && !PRESET;
    assign tx_busy           = (r_state != S_IDLE) || r_hold_valid;
    assign tx_buffer_overrun = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module : tb_uart_tx_serializer
// Scoreboard bench: frames queued at tx_start, decoded from TXD per baud tick.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int TPB = 16;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [6:0] ctrl = 7'h00;
    logic       ovr_clr = 1'b0;
    logic       TXD, TXdone, tx_busy, tx_buffer_overrun;

    always #5 PCLK = ~PCLK;

    uart_tx_serializer #(.TICKS_PER_BIT(TPB), .DATA_W(8)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET), .baud_tick(baud_tick), .tx_start(tx_start),
        .tx_data(tx_data), .ctrl(ctrl), .ovr_clr(ovr_clr), .TXD(TXD),
        .TXdone(TXdone), .tx_busy(tx_busy), .tx_buffer_overrun(tx_buffer_overrun)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [6:0] ctrl;
    } frame_t;

    frame_t exp_q[$];
    int     exp_done = 0;

    // Reference frame: bit 0 is the start bit, unused upper bits stay 1
    function automatic void build(input logic [7:0] d, input logic [6:0] c,
                                  output logic [15:0] bits, output int n);
        int  nd;
        logic p;
        nd   = 5 + int'(c[1:0]);
        bits = '1;
        bits[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < nd; i++) begin
            bits[1 + i] = d[i];
            p = p ^ d[i];
        end
        n = 1 + nd;
        if (c[2]) begin
            bits[n] = p ^ c[3];
            n++;
        end
        n = n + (c[4] ? 2 : 1);
    endfunction

    int tick_div = 2;
    bit tick_cont = 1'b0;
    int tick_cnt = 0;
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            if (tick_cont) begin
                baud_tick = 1'b1;
            end else begin
                tick_cnt  = (tick_cnt + 1) % tick_div;
                baud_tick = (tick_cnt == 0);
            end
        end
    end

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int done_total = 0;
    always @(negedge PCLK) if (TXdone === 1'b1) done_total++;

    int frames_seen = 0;
    int last_done_cyc = -100;
    int last_gap = 0;

    initial begin
        frame_t      f;
        logic [15:0] eb, rb;
        int          n, ticks, errs, idx;
        bit          fin, ab;
        forever begin
            @(negedge PCLK);
            if (!PRESET && TXD === 1'b0) begin
                last_gap = cyc - last_done_cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    f.data = 8'h00;
                    f.ctrl = 7'h03;
                end else begin
                    f = exp_q.pop_front();
                end
                build(f.data, f.ctrl, eb, n);
                rb = '1; ticks = 0; errs = 0; fin = 1'b0; ab = 1'b0;
                while (!fin) begin
                    if (PRESET) begin
                        ab  = 1'b1;
                        fin = 1'b1;
                    end else if (baud_tick) begin
                        idx = ticks / TPB;
                        if (idx < 16) begin
                            if (TXD !== eb[idx]) errs++;
                            if ((ticks % TPB) == TPB / 2) rb[idx] = TXD;
                        end
                        ticks++;
                        if (TXdone === 1'b1 || ticks >= TPB * 16) fin = 1'b1;
                    end
                    if (!fin) @(negedge PCLK);
                end
                if (!ab) begin
                    check("frame_len", ticks, TPB * n);
                    check("frame_bits", rb, eb);
                    check("bit_stable", errs, 0);
                    frames_seen++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [6:0] c, input bit push);
        @(posedge PCLK);
        #1;
        tx_start = 1'b1;
        tx_data  = d;
        ctrl     = c;
        if (push) begin
            exp_q.push_back('{d, c});
            exp_done++;
        end
        @(posedge PCLK);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < 20000) begin
            @(negedge PCLK);
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n >= 20000), 0);
        repeat (4) @(negedge PCLK);
    endtask

    initial begin
        int base, busy_low, n, tk, dt;

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_txd", TXD, 1);
        check("rst_txdone", TXdone, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_ovr", tx_buffer_overrun, 0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        repeat (3) @(posedge PCLK);

        send(8'hA5, 7'h03, 1'b1);
        @(negedge PCLK);
        check("start_latency_txd", TXD, 0);
        check("busy_rise", tx_busy, 1);
        drain("8n1");

        tick_cont = 1'b1;
        send(8'hA5, 7'h63, 1'b1);
        drain("8n1_cont_tick");
        tick_cont = 1'b0;

        send(8'h53, 7'h16, 1'b1);
        drain("7e2");

        send(8'h1F, 7'h0C, 1'b1);
        ctrl = 7'h7F;
        drain("5o1");

        base = frames_seen;
        send(8'h11, 7'h03, 1'b1);
        @(posedge PCLK);
        send(8'h22, 7'h03, 1'b1);
        busy_low = 0;
        n = 0;
        while (frames_seen < base + 2 && n < 20000) begin
            @(negedge PCLK);
            if (frames_seen < base + 2 && tx_busy !== 1'b1) busy_low++;
            n++;
        end
        check("b2b_busy_low", busy_low, 0);
        check("b2b_gap", last_gap, 1);
        drain("b2b");
        check("b2b_frames", frames_seen - base, 2);

        base = frames_seen;
        send(8'h3C, 7'h03, 1'b1);
        send(8'h5A, 7'h16, 1'b1);
        @(negedge PCLK);
        check("ovr_pre", tx_buffer_overrun, 0);
        send(8'h77, 7'h03, 1'b0);
        @(negedge PCLK);
        check("ovr_set", tx_buffer_overrun, 1);
        @(posedge PCLK);
        #1;
        tx_start = 1'b1;
        tx_data  = 8'h99;
        ovr_clr  = 1'b1;
        @(posedge PCLK);
        #1;
        tx_start = 1'b0;
        ovr_clr  = 1'b0;
        @(negedge PCLK);
        check("ovr_set_wins", tx_buffer_overrun, 1);
        @(posedge PCLK);
        #1;
        ovr_clr = 1'b1;
        @(posedge PCLK);
        #1;
        ovr_clr = 1'b0;
        @(negedge PCLK);
        check("ovr_clear", tx_buffer_overrun, 0);
        drain("ovr");
        check("ovr_frames", frames_seen - base, 2);

        send(8'hC3, 7'h03, 1'b1);
        exp_done--;
        tk = 0;
        n = 0;
        while (tk < 70 && n < 2000) begin
            @(negedge PCLK);
            if (baud_tick) tk++;
            n++;
        end
        dt = done_total;
        @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_mid_txd", TXD, 1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_txdone", TXdone, 0);
        repeat (40) @(negedge PCLK);
        check("rst_mid_no_done", done_total - dt, 0);
        send(8'h3A, 7'h03, 1'b1);
        drain("post_rst");

        check("done_total", done_total, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
